// File: rtl/ddf_pkg.sv
// Shared types and helpers for the dynamic dataflow fabric join actors.
package ddf_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_ADD  = 2'd1,
    OP_MAX  = 2'd2,
    OP_MIN  = 2'd3
  } op_e;

  localparam int TOK_MAX_W = 64;

  function automatic int tag_width(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  // Token layout is {tag, data} with the tag in the MSBs; callers truncate to their token width.
  function automatic logic [TOK_MAX_W-1:0] pack_token(input logic [31:0] tag,
                                                      input logic [31:0] data,
                                                      input int data_w);
    return (TOK_MAX_W'(tag) << data_w) | TOK_MAX_W'(data);
  endfunction

endpackage

// File: rtl/ddf_rr_arbiter.sv
// Round-robin arbiter: grants the first request after the last grant, pointer advances on adv.
// Combinational grant; pointer update on the rising edge.
module ddf_rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] last;
  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= IW'(N - 1);
    end else if (adv && any) begin
      last <= idx;
    end
  end

endmodule

// File: rtl/ddf_join_rr.sv
// Multi-port, multi-flux join: fires a flux when every port holds a token, combines them, emits one tagged result.
// Fire -> read in cycle N, result buffered at end of N+1, write from N+2; a 2-entry buffer absorbs full.
module ddf_join_rr
  import ddf_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int FLUX       = 2,
  parameter  int PORTS      = 2,
  localparam int TAG_W      = tag_width(FLUX),
  localparam int TOK_W      = DATA_WIDTH + TAG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             op,
  output logic [TOK_W-1:0]       din,
  output logic                   write,
  input  logic                   full,
  input  logic [TOK_W*PORTS-1:0] dout,
  output logic [FLUX*PORTS-1:0]  read,
  input  logic [FLUX*PORTS-1:0]  empty,
  output logic                   tag_err
);

  logic [FLUX-1:0]       ready;
  logic [FLUX-1:0]       gnt;
  logic [TAG_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic                  fire;
  logic                  s2_vld;
  logic [TAG_W-1:0]      s2_tag;
  op_e                   s2_op;
  logic [1:0]            occ;
  logic [TOK_W-1:0]      ent [2];
  logic [TOK_W-1:0]      push_tok;
  logic [DATA_WIDTH-1:0] result;
  logic                  tag_mis;

  always_comb begin
    ready = '1;
    for (int f = 0; f < FLUX; f++) begin
      for (int p = 0; p < PORTS; p++) begin
        if (empty[p*FLUX+f]) ready[f] = 1'b0;
      end
    end
  end

  ddf_rr_arbiter #(.N(FLUX)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (ready),
    .adv (fire),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign write = (occ != 2'd0) && !full;
  assign din   = ent[0];

  // Space check counts the in-flight S2 result and the head leaving this cycle; reset holds reads low.
  assign fire = rst && gnt_any &&
                (({1'b0, occ} + {2'b00, s2_vld} - {2'b00, write}) < 3'd2);

  always_comb begin
    read = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int f = 0; f < FLUX; f++) begin
        read[p*FLUX+f] = fire & gnt[f];
      end
    end
  end

  always_comb begin
    logic [DATA_WIDTH-1:0] d;
    logic [TAG_W-1:0]      t;
    result  = dout[DATA_WIDTH-1:0];
    tag_mis = 1'b0;
    d       = '0;
    t       = '0;
    for (int p = 0; p < PORTS; p++) begin
      d = dout[p*TOK_W +: DATA_WIDTH];
      t = dout[p*TOK_W+DATA_WIDTH +: TAG_W];
      if (t != s2_tag) tag_mis = 1'b1;
      if (p > 0) begin
        case (s2_op)
          OP_ADD:  result = result + d;
          OP_MAX:  if (d > result) result = d;
          OP_MIN:  if (d < result) result = d;
          default: ;
        endcase
      end
    end
  end

  assign push_tok = TOK_W'(pack_token(32'(s2_tag), 32'(result), DATA_WIDTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld  <= 1'b0;
      s2_tag  <= '0;
      s2_op   <= OP_PASS;
      tag_err <= 1'b0;
    end else begin
      s2_vld <= fire;
      if (fire) begin
        s2_tag <= gnt_idx;
        s2_op  <= op_e'(op);
      end
      if (s2_vld && tag_mis) tag_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ    <= 2'd0;
      ent[0] <= '0;
      ent[1] <= '0;
    end else begin
      case ({s2_vld, write})
        2'b10: begin
          if (occ == 2'd0) ent[0] <= push_tok;
          else             ent[1] <= push_tok;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent[0] <= ent[1];
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent[0] <= push_tok;
          end else begin
            ent[0] <= ent[1];
            ent[1] <= push_tok;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(s2_vld && !write && occ == 2'd2));

endmodule
